// File: rtl/cpu_defs_pkg.sv
// Shared fetch-path definitions: default widths and the slot/bundle types
// that travel between the ICache output stage and IF3.
package cpu_defs_pkg;

  localparam int FETCH_WIDTH_DEF = 2;
  localparam int SKID_DEPTH_DEF  = 2;
  localparam int SLOT_W_DEF      = 64;

  typedef logic [SLOT_W_DEF-1:0] slot_t;

  typedef struct packed {
    logic [FETCH_WIDTH_DEF-1:0] valid;
    slot_t [FETCH_WIDTH_DEF-1:0] slot;
  } bundle_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Circular overrun buffer holding whole fetch bundles while IF3 is paused.
// Pop is evaluated before push, so a full buffer accepts a push in a pop cycle.
module fetch_skid_fifo
  import cpu_defs_pkg::*;
#(
  parameter  int WIDTH = $bits(bundle_t),
  parameter  int DEPTH = SKID_DEPTH_DEF,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign count_o     = count_q;
  assign head_data_o = mem_q[head_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_pop)  head_q <= ptr_next(head_q);
      if (do_push) tail_q <= ptr_next(tail_q);
      count_q <= count_d;
    end
  end

  // Storage is not reset: the pointers and count alone define what is live.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[tail_q] <= push_data_i;
  end

endmodule

// File: rtl/if_stage_skid_reg.sv
// IF2->IF3 pipeline register with an overrun skid buffer, flush with
// delay-slot rescue, and an upstream pause request while replay is pending.
module if_stage_skid_reg
  import cpu_defs_pkg::*;
#(
  parameter  int FETCH_WIDTH = FETCH_WIDTH_DEF,
  parameter  int SKID_DEPTH  = SKID_DEPTH_DEF,
  parameter  int SLOT_W      = SLOT_W_DEF,
  localparam int CNT_W       = $clog2(SKID_DEPTH + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          pause_i,
  input  logic                          rescue_ds_i,
  input  logic                          in_overrun_i,
  input  logic [FETCH_WIDTH-1:0]        in_valid_i,
  input  logic [FETCH_WIDTH*SLOT_W-1:0] in_slot_i,
  output logic [FETCH_WIDTH-1:0]        out_valid_o,
  output logic [FETCH_WIDTH*SLOT_W-1:0] out_slot_o,
  output logic                          pause_req_o,
  output logic [CNT_W-1:0]              skid_count_o,
  output logic                          overflow_err_o
);

  localparam int DATA_W   = FETCH_WIDTH * SLOT_W;
  localparam int BUNDLE_W = FETCH_WIDTH + DATA_W;

  logic [FETCH_WIDTH-1:0] out_valid_q, out_valid_d;
  logic [DATA_W-1:0]      out_slot_q, out_slot_d;
  logic                   overflow_q, overflow_d;

  logic                   skid_push, skid_pop, skid_clear;
  logic                   skid_full, skid_empty;
  logic [BUNDLE_W-1:0]    skid_head;
  logic [FETCH_WIDTH-1:0] head_valid;
  logic [DATA_W-1:0]      head_slot;
  logic                   incoming_live;

  fetch_skid_fifo #(
    .WIDTH (BUNDLE_W),
    .DEPTH (SKID_DEPTH)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (skid_clear),
    .push_i      (skid_push),
    .pop_i       (skid_pop),
    .push_data_i ({in_valid_i, in_slot_i}),
    .head_data_o (skid_head),
    .count_o     (skid_count_o),
    .full_o      (skid_full),
    .empty_o     (skid_empty)
  );

  assign head_valid    = skid_head[BUNDLE_W-1 -: FETCH_WIDTH];
  assign head_slot     = skid_head[DATA_W-1:0];
  assign incoming_live = in_overrun_i && (|in_valid_i);

  // Flush beats pause, pause beats replay, replay beats the live input.
  always_comb begin
    out_valid_d = out_valid_q;
    out_slot_d  = out_slot_q;
    overflow_d  = overflow_q;
    skid_push   = 1'b0;
    skid_pop    = 1'b0;
    skid_clear  = 1'b0;
    if (flush_i && rescue_ds_i) begin
      skid_clear  = 1'b1;
      out_valid_d = '0;
      out_slot_d  = '0;
      if (!skid_empty) begin
        out_valid_d[0]           = head_valid[0];
        out_slot_d[SLOT_W-1:0]   = head_slot[SLOT_W-1:0];
      end else begin
        out_valid_d[0]           = in_valid_i[0];
        out_slot_d[SLOT_W-1:0]   = in_slot_i[SLOT_W-1:0];
      end
    end else if (flush_i) begin
      skid_clear  = 1'b1;
      out_valid_d = '0;
    end else if (pause_i) begin
      if (incoming_live) begin
        if (skid_full) overflow_d = 1'b1;
        else           skid_push  = 1'b1;
      end
    end else if (!skid_empty) begin
      out_valid_d = head_valid;
      out_slot_d  = head_slot;
      skid_pop    = 1'b1;
      skid_push   = incoming_live;
    end else begin
      out_valid_d = in_valid_i;
      out_slot_d  = in_slot_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= '0;
      out_slot_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_slot_q  <= out_slot_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid_o    = out_valid_q;
  assign out_slot_o     = out_slot_q;
  assign overflow_err_o = overflow_q;
  assign pause_req_o    = (skid_count_o != '0);

endmodule
